bram_ctrl: RTL and testbench

//  Word-organised block-RAM controller that serves the CPU's split read/write memory port.

---
 rtl/bram_ctrl_if.sv | 33 +++
 rtl/bram_ctrl.sv | 152 +++++++++++++++
 tb/tb_bram_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_ctrl_if.sv
// bram_ctrl_if: CPU <-> block-RAM controller memory port.
//   master: CPU side (drives read request/address and write strobe/address/data)
//   slave : controller side (returns read data/valid, fault flag and LED register)
// Signals:
//   rd_en, rd_addr[ADDR_W]   read request and byte address
//   rd_data[32], rd_valid    read data and its one-cycle valid pulse
//   wr_en, wr_addr[ADDR_W],
//   wr_data[32]              fire-and-forget write
//   fault                    sticky out-of-range indication
//   leds[8]                  MMIO output register
interface bram_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              fault;
  logic [7:0]        leds;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, rd_valid, fault, leds
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, rd_valid, fault, leds
  );
endinterface

// File: rtl/bram_ctrl.sv
// bram_ctrl: word-organised block-RAM controller for the CPU split memory port.
//   Words 0..31 hold the register file (x0 is hardwired to zero), program/data
//   start at byte 0x80. Reads use a request/valid handshake with RD_LATENCY
//   edges from acceptance to rd_valid; writes complete on the strobe edge.
// Ports:
//   clk  in   clock, all logic on posedge
//   rst  in   synchronous reset, active-high
//   bus  slave modport of bram_ctrl_if (read/write port, fault, leds)
// Parameters: ADDR_W (byte address width), DEPTH (words), RD_LATENCY (1..15),
//   INIT_FILE (image name, not loaded in this build).
// Build option: define BRAM_CTRL_MMIO_EN to map byte address {ADDR_W{1}} & ~3
//   to the 8-bit leds register; otherwise leds reads as 0 and that address
//   is an ordinary out-of-range location.
module bram_ctrl #(
  parameter int    ADDR_W     = 16,
  parameter int    DEPTH      = 256,
  parameter int    RD_LATENCY = 1,
  parameter string INIT_FILE  = ""
) (
  input logic        clk,
  input logic        rst,
  bram_ctrl_if.slave bus
);

  localparam int             IDX_W   = ADDR_W - 2;
  localparam int             RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_V = (IDX_W + 1)'(DEPTH);
  localparam logic [3:0]     LAT_M1  = 4'(RD_LATENCY - 1);

`ifdef BRAM_CTRL_MMIO_EN
  localparam logic MMIO_EN = 1'b1;
`else
  localparam logic MMIO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, VALID, ACK} state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      rd_data_q;
  logic             rd_valid_q;
  logic             fault_q;
  logic [7:0]       leds_v;
  logic [31:0]      mem_q [DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             unused_addr_lsbs;

  // Byte offsets are ignored: the port only moves whole words.
  assign rd_idx           = bus.rd_addr[ADDR_W-1:2];
  assign wr_idx           = bus.wr_addr[ADDR_W-1:2];
  assign unused_addr_lsbs = ^{bus.rd_addr[1:0], bus.wr_addr[1:0]};

  function automatic logic is_mmio(input logic [IDX_W-1:0] idx);
    return MMIO_EN && (idx == {IDX_W{1'b1}});
  endfunction

  // MMIO takes priority even when DEPTH spans the whole address space.
  function automatic logic in_ram(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < DEPTH_V) && !is_mmio(idx);
  endfunction

  // RAM write port: x0 and out-of-range words are never written; a write
  // coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && bus.wr_en && in_ram(wr_idx) && (wr_idx != '0)) begin
      mem_q[wr_idx[RAM_AW-1:0]] <= bus.wr_data;
    end
  end

`ifdef BRAM_CTRL_MMIO_EN
  logic [7:0] leds_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q <= '0;
    end else if (bus.wr_en && is_mmio(wr_idx)) begin
      leds_q <= bus.wr_data[7:0];
    end
  end

  assign leds_v = leds_q;
`else
  assign leds_v = '0;
`endif

  // Read FSM. WAIT counts down RD_LATENCY-1 extra edges; the edge leaving
  // WAIT with a zero count is the one that samples the RAM (read-first with
  // respect to a same-edge write) and raises rd_valid for the VALID cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;

      if (bus.wr_en && !in_ram(wr_idx) && !is_mmio(wr_idx)) begin
        fault_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (bus.rd_en) begin
            idx_q   <= rd_idx;
            cnt_q   <= LAT_M1;
            state_q <= WAIT;
            if (!in_ram(rd_idx) && !is_mmio(rd_idx)) begin
              fault_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q    <= VALID;
            rd_valid_q <= 1'b1;
            if (is_mmio(idx_q)) begin
              rd_data_q <= {24'b0, leds_v};
            end else if (in_ram(idx_q) && (idx_q != '0)) begin
              rd_data_q <= mem_q[idx_q[RAM_AW-1:0]];
            end else begin
              rd_data_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        VALID: begin
          state_q <= ACK;
        end
        ACK: begin
          // Hold off until the requester has dropped rd_en so the same
          // request is not served twice.
          if (!bus.rd_en) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.fault    = fault_q;
  assign bus.leds     = leds_v;

endmodule

// File: tb/tb_bram_ctrl.sv
// tb_bram_ctrl: directed bench for bram_ctrl. Two instances (RD_LATENCY 1
// and 3) share one stimulus stream; each task checks one feature.
module tb_bram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic [15:0] rd_addr = '0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_ctrl_if #(.ADDR_W(16)) if1 ();
  bram_ctrl_if #(.ADDR_W(16)) if3 ();

  assign if1.rd_en   = rd_en;
  assign if1.rd_addr = rd_addr;
  assign if1.wr_en   = wr_en;
  assign if1.wr_addr = wr_addr;
  assign if1.wr_data = wr_data;
  assign if3.rd_en   = rd_en;
  assign if3.rd_addr = rd_addr;
  assign if3.wr_en   = wr_en;
  assign if3.wr_addr = wr_addr;
  assign if3.wr_data = wr_data;

  bram_ctrl #(.ADDR_W(16), .DEPTH(256), .RD_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  bram_ctrl #(.ADDR_W(16), .DEPTH(256), .RD_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .bus(if3.slave)
  );

  task automatic do_write(input logic [15:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Issues a read, returns data and edges from acceptance to rd_valid
  // (-1 when no pulse arrives within the budget).
  task automatic do_read(input logic sel, input logic [15:0] addr,
                         output logic [31:0] data, output int lat);
    logic v;
    lat = -1;
    data = '0;
    @(posedge clk); #1;
    rd_en = 1'b1; rd_addr = addr;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      v = sel ? if3.rd_valid : if1.rd_valid;
      if (v) begin
        lat = i;
        data = sel ? if3.rd_data : if1.rd_data;
        break;
      end
    end
    rd_en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (if1.rd_valid !== 1'b0) begin
      $display("FAIL reset_rd_valid got=%0b exp=0", if1.rd_valid); failures++;
    end
    checks++;
    if (if1.rd_data !== 32'h0) begin
      $display("FAIL reset_rd_data got=%h exp=00000000", if1.rd_data); failures++;
    end
    checks++;
    if (if1.fault !== 1'b0 || if3.fault !== 1'b0) begin
      $display("FAIL reset_fault got=%0b/%0b exp=0/0", if1.fault, if3.fault); failures++;
    end
    checks++;
    if (if1.leds !== 8'h00) begin
      $display("FAIL reset_leds got=%h exp=00", if1.leds); failures++;
    end
  endtask

  task automatic test_read_latency();
    logic [31:0] d;
    int lat;
    do_write(16'h0080, 32'h0050_0093);
    do_read(1'b0, 16'h0080, d, lat);
    checks++;
    if (d !== 32'h0050_0093) begin
      $display("FAIL l1_read_data got=%h exp=00500093", d); failures++;
    end
    checks++;
    if (lat != 1) begin
      $display("FAIL l1_latency got=%0d exp=1", lat); failures++;
    end
    checks++;
    if (if1.rd_data !== 32'h0050_0093) begin
      $display("FAIL l1_data_held got=%h exp=00500093", if1.rd_data); failures++;
    end
    do_read(1'b1, 16'h0080, d, lat);
    checks++;
    if (d !== 32'h0050_0093) begin
      $display("FAIL l3_read_data got=%h exp=00500093", d); failures++;
    end
    checks++;
    if (lat != 3) begin
      $display("FAIL l3_latency got=%0d exp=3", lat); failures++;
    end
  endtask

  task automatic test_write();
    logic [31:0] d;
    int lat;
    do_write(16'h0014, 32'hDEAD_BEEF);
    do_read(1'b0, 16'h0014, d, lat);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin
      $display("FAIL wr_x5 got=%h exp=deadbeef", d); failures++;
    end
    do_read(1'b1, 16'h0017, d, lat);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin
      $display("FAIL wr_x5_bytelsb got=%h exp=deadbeef", d); failures++;
    end
    do_write(16'h0000, 32'h1234_5678);
    do_read(1'b0, 16'h0000, d, lat);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL wr_x0_protect got=%h exp=00000000", d); failures++;
    end
    checks++;
    if (if1.fault !== 1'b0) begin
      $display("FAIL wr_no_fault got=%0b exp=0", if1.fault); failures++;
    end
  endtask

  task automatic test_hold_rd_en();
    int pulses;
    pulses = 0;
    @(posedge clk); #1;
    rd_en = 1'b1; rd_addr = 16'h0080;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (if1.rd_valid) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      $display("FAIL hold_single_pulse got=%0d exp=1", pulses); failures++;
    end
    rd_en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    pulses = 0;
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (if1.rd_valid) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      $display("FAIL rerequest_pulse got=%0d exp=1", pulses); failures++;
    end
    rd_en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_read_first();
    logic [31:0] d;
    int lat;
    do_write(16'h0040, 32'h1111_1111);
    @(posedge clk); #1;
    rd_en = 1'b1; rd_addr = 16'h0040;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 16'h0040; wr_data = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    wr_en = 1'b0;
    checks++;
    if (if1.rd_valid !== 1'b1 || if1.rd_data !== 32'h1111_1111) begin
      $display("FAIL read_first got valid=%0b data=%h exp valid=1 data=11111111",
               if1.rd_valid, if1.rd_data);
      failures++;
    end
    rd_en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    do_read(1'b0, 16'h0040, d, lat);
    checks++;
    if (d !== 32'hA5A5_A5A5) begin
      $display("FAIL read_after_write got=%h exp=a5a5a5a5", d); failures++;
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    int lat;
    int pulses;
    do_read(1'b0, 16'h1000, d, lat);
    checks++;
    if (d !== 32'h0 || lat != 1) begin
      $display("FAIL oor_read got data=%h lat=%0d exp data=00000000 lat=1", d, lat); failures++;
    end
    checks++;
    if (if1.fault !== 1'b1) begin
      $display("FAIL oor_fault got=%0b exp=1", if1.fault); failures++;
    end
    do_reset();
    checks++;
    if (if1.fault !== 1'b0) begin
      $display("FAIL oor_fault_clear got=%0b exp=0", if1.fault); failures++;
    end
    do_write(16'h2000, 32'h0000_0001);
    checks++;
    if (if1.fault !== 1'b1) begin
      $display("FAIL oor_write_fault got=%0b exp=1", if1.fault); failures++;
    end
    do_reset();
    // reset during WAIT aborts the read and drops a same-edge write
    do_write(16'h0018, 32'h0000_600D);
    @(posedge clk); #1;
    rd_en = 1'b1; rd_addr = 16'h0080;
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b1; wr_addr = 16'h0018; wr_data = 32'h0000_0BAD;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (if1.rd_valid || if3.rd_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      $display("FAIL rst_abort_pulses got=%0d exp=0", pulses); failures++;
    end
    do_read(1'b0, 16'h0018, d, lat);
    checks++;
    if (d !== 32'h0000_600D) begin
      $display("FAIL rst_write_dropped got=%h exp=0000600d", d); failures++;
    end
  endtask

  task automatic test_mmio();
    logic [31:0] d;
    int lat;
    do_reset();
    do_write(16'hFFFC, 32'h0000_01C3);
    do_read(1'b0, 16'hFFFC, d, lat);
`ifdef BRAM_CTRL_MMIO_EN
    checks++;
    if (if1.leds !== 8'hC3) begin
      $display("FAIL mmio_leds got=%h exp=c3", if1.leds); failures++;
    end
    checks++;
    if (d !== 32'h0000_00C3) begin
      $display("FAIL mmio_read got=%h exp=000000c3", d); failures++;
    end
    checks++;
    if (if1.fault !== 1'b0) begin
      $display("FAIL mmio_fault got=%0b exp=0", if1.fault); failures++;
    end
`else
    checks++;
    if (if1.leds !== 8'h00) begin
      $display("FAIL nommio_leds got=%h exp=00", if1.leds); failures++;
    end
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL nommio_read got=%h exp=00000000", d); failures++;
    end
    checks++;
    if (if1.fault !== 1'b1) begin
      $display("FAIL nommio_fault got=%0b exp=1", if1.fault); failures++;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write();
    test_hold_rd_en();
    test_read_first();
    test_out_of_range();
    test_mmio();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
